// File: rtl/dae_issue_unit.sv
// Issue/writeback stage for the Decode_And_Execute ALU: instruction FIFO, 4x4-bit
// register file, registered operand issue with read-after-write bypass, and retire counter.
module dae_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8:0]             in_instr,
  input  logic                   stall,
  output logic [3:0]             ex_rs,
  output logic [3:0]             ex_rt,
  output logic [2:0]             ex_sel,
  output logic                   ex_valid,
  input  logic [3:0]             ex_rd,
  input  logic [1:0]             dbg_addr,
  output logic [3:0]             dbg_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             retired
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on occupancy, never on in_valid or a same-cycle pop.

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_regs [4];
  logic [3:0]    r_ex_rs;
  logic [3:0]    r_ex_rt;
  logic [2:0]    r_ex_sel;
  logic [1:0]    r_ex_dst;
  logic          r_ex_valid;
  logic [7:0]    r_retired;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_wb;
  logic [8:0]    w_head;
  logic [3:0]    w_opnd_s;
  logic [3:0]    w_opnd_t;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && !w_full;
  assign w_pop    = !stall && !w_empty;
  assign w_wb     = !stall && r_ex_valid;
  assign w_head   = r_mem[r_rd_ptr];

  // The in-flight result is written on the same edge the next instruction issues,
  // so a matching source must take ex_rd rather than the stale register.
  always_comb begin
    w_opnd_s = r_regs[w_head[3:2]];
    w_opnd_t = r_regs[w_head[1:0]];
    if (r_ex_valid && (w_head[3:2] == r_ex_dst)) w_opnd_s = ex_rd;
    if (r_ex_valid && (w_head[1:0] == r_ex_dst)) w_opnd_t = ex_rd;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_sel   <= '0;
      r_ex_dst   <= '0;
      r_ex_valid <= 1'b0;
    end else if (!stall) begin
      r_ex_valid <= !w_empty;
      if (!w_empty) begin
        r_ex_sel <= w_head[8:6];
        r_ex_dst <= w_head[5:4];
        r_ex_rs  <= w_opnd_s;
        r_ex_rt  <= w_opnd_t;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= 4'(i);
      r_retired <= '0;
    end else if (w_wb) begin
      r_regs[r_ex_dst] <= ex_rd;
      r_retired        <= r_retired + 8'd1;
    end
  end

  assign in_ready   = !w_full;
  assign ex_rs      = r_ex_rs;
  assign ex_rt      = r_ex_rt;
  assign ex_sel     = r_ex_sel;
  assign ex_valid   = r_ex_valid;
  assign dbg_data   = r_regs[dbg_addr];
  assign fifo_count = r_count;
  assign retired    = r_retired;

endmodule

// File: tb/tb_dae_issue_unit.sv
// Directed bench for dae_issue_unit with a reference ALU closing the ex_* -> ex_rd loop.
module tb_dae_issue_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic       stall;
  logic [3:0] ex_rs;
  logic [3:0] ex_rt;
  logic [2:0] ex_sel;
  logic       ex_valid;
  logic [3:0] ex_rd;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
  logic [2:0] fifo_count;
  logic [7:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  dae_issue_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .stall(stall), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_sel(ex_sel), .ex_valid(ex_valid), .ex_rd(ex_rd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .fifo_count(fifo_count), .retired(retired)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference ALU: 000 sub, 001 add, 010 or, 011 and, 100 xor
  function automatic logic [3:0] alu(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'b000:  return a - b;
      3'b001:  return a + b;
      3'b010:  return a | b;
      3'b011:  return a & b;
      3'b100:  return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  assign ex_rd = alu(ex_sel, ex_rs, ex_rt);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; stall = 1'b0; dbg_addr = 2'd2;
    #1;
    // 1. reset state
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_count",    32'(fifo_count), 0);
    check("rst_retired",  32'(retired), 0);
    check("rst_dbg_r2",   32'(dbg_data), 2);
    step();
    rst = 1'b0;

    // 2. single ADD r0 = r1 + r2
    in_valid = 1'b1; in_instr = 9'b001_00_01_10;
    step();
    in_valid = 1'b0;
    check("t2_count",     32'(fifo_count), 1);
    check("t2_no_bypass", 32'(ex_valid), 0);
    step();
    check("t2_ex_valid", 32'(ex_valid), 1);
    check("t2_ex_rs",    32'(ex_rs), 1);
    check("t2_ex_rt",    32'(ex_rt), 2);
    check("t2_ex_sel",   32'(ex_sel), 1);
    step();
    check("t2_retired", 32'(retired), 1);
    check_reg("t2_r0", 2'd0, 4'd3);

    // 3. back-to-back dependency, from fresh reset
    rst = 1'b1; #1; rst = 1'b0;
    in_valid = 1'b1; in_instr = 9'b001_00_01_10;
    step();
    in_instr = 9'b000_01_00_11;
    step();
    in_valid = 1'b0;
    check("t3_first_rs", 32'(ex_rs), 1);
    step();
    check("t3_bypass_rs", 32'(ex_rs), 3);
    check("t3_rt",        32'(ex_rt), 3);
    check("t3_sel",       32'(ex_sel), 0);
    step();
    check("t3_retired", 32'(retired), 2);
    check("t3_idle",    32'(ex_valid), 0);
    check_reg("t3_r0", 2'd0, 4'd3);
    check_reg("t3_r1", 2'd1, 4'd0);
    // regs now r0=3 r1=0 r2=2 r3=3, retired=2

    // 4. fill FIFO under stall behind an in-flight instruction
    in_valid = 1'b1; in_instr = 9'b001_01_10_11;     // I0: r1 = r2 + r3 = 5
    step();
    in_valid = 1'b0;
    step();
    check("t4_i0_live", 32'(ex_valid), 1);
    stall = 1'b1; in_valid = 1'b1;
    in_instr = 9'b001_01_01_01; step();               // I1: r1 = r1 + r1
    in_instr = 9'b000_10_01_11; step();               // I2: r2 = r1 - r3
    in_instr = 9'b001_00_10_00; step();               // I3: r0 = r2 + r0
    check("t4_ready_at3", 32'(in_ready), 1);
    in_instr = 9'b010_11_00_01; step();               // I4: r3 = r0 | r1
    check("t4_count_full", 32'(fifo_count), 4);
    check("t4_ready_full", 32'(in_ready), 0);
    in_instr = 9'b001_00_00_00; step();               // I5: must be refused
    in_valid = 1'b0;
    check("t4_count_hold", 32'(fifo_count), 4);
    check("t4_stall_ret",  32'(retired), 2);
    check("t4_stall_rs",   32'(ex_rs), 2);
    check("t4_stall_vld",  32'(ex_valid), 1);
    check_reg("t4_stall_r1", 2'd1, 4'd0);
    stall = 1'b0;
    step();
    check("t4_r1_ret",  32'(retired), 3);
    check("t4_r1_rs",   32'(ex_rs), 5);
    check("t4_r1_rt",   32'(ex_rt), 5);
    step();
    check("t4_r2_ret",  32'(retired), 4);
    check("t4_r2_rs",   32'(ex_rs), 10);
    check("t4_r2_rt",   32'(ex_rt), 3);
    check("t4_r2_vld",  32'(ex_valid), 1);
    step();
    check("t4_r3_ret",  32'(retired), 5);
    check("t4_r3_rs",   32'(ex_rs), 7);
    check("t4_r3_vld",  32'(ex_valid), 1);
    step();
    check("t4_r4_ret",  32'(retired), 6);
    check("t4_r4_rs",   32'(ex_rs), 10);
    check("t4_r4_sel",  32'(ex_sel), 2);
    step();
    check("t4_r5_ret",  32'(retired), 7);
    check("t4_r5_vld",  32'(ex_valid), 0);
    check("t4_r5_cnt",  32'(fifo_count), 0);
    step();
    check("t4_r6_ret",  32'(retired), 7);
    check_reg("t4_r0", 2'd0, 4'd10);
    check_reg("t4_r1", 2'd1, 4'd10);
    check_reg("t4_r2", 2'd2, 4'd7);
    check_reg("t4_r3", 2'd3, 4'd10);

    // 5. asynchronous reset mid-operation
    in_valid = 1'b1; in_instr = 9'b001_00_01_10;
    step();
    in_valid = 1'b0;
    step();
    stall = 1'b1; in_valid = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    check("t5_pre_cnt", 32'(fifo_count), 3);
    check("t5_pre_vld", 32'(ex_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_vld",     32'(ex_valid), 0);
    check("t5_cnt",     32'(fifo_count), 0);
    check("t5_ret",     32'(retired), 0);
    check("t5_ready",   32'(in_ready), 1);
    check_reg("t5_r0", 2'd0, 4'd0);
    check_reg("t5_r1", 2'd1, 4'd1);
    check_reg("t5_r2", 2'd2, 4'd2);
    check_reg("t5_r3", 2'd3, 4'd3);
    rst = 1'b0; stall = 1'b0;
    step(); step(); step();
    check("t5_post_ret", 32'(retired), 0);
    check("t5_post_vld", 32'(ex_valid), 0);
    check("t5_post_cnt", 32'(fifo_count), 0);
    check_reg("t5_post_r0", 2'd0, 4'd0);

    // 6. 256 x OR r2 = r2 | r2, retired wraps
    in_instr = 9'b010_10_10_10;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("t6_ret_mid", 32'(retired), 254);
    step();
    check("t6_ret_255", 32'(retired), 255);
    check("t6_last_vld", 32'(ex_valid), 1);
    step();
    check("t6_ret_wrap", 32'(retired), 0);
    check("t6_idle",     32'(ex_valid), 0);
    check("t6_cnt",      32'(fifo_count), 0);
    check_reg("t6_r2", 2'd2, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
